// File: rtl/ip_tx_pkg.sv
// Shared constants, types and helpers for the IPv4 transmit stage.
package ip_tx_pkg;
  localparam logic [7:0] IP_VER_IHL   = 8'h45;
  localparam logic [7:0] IP_TOS       = 8'h00;
  localparam int         IP_HDR_BYTES = 20;
  localparam logic [7:0] IP_PROTO_UDP = 8'd17;
  localparam int         FLAG_DF      = 1;
  localparam int         FLAG_MF      = 0;
  localparam int         FREE_THRESH  = 190;
  localparam int         DFIFO_W      = 73;
  localparam int         DFIFO_D      = 512;
  localparam int         UFIFO_W      = 40;
  localparam int         UFIFO_D      = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CSUM, ST_HDR0, ST_HDR1, ST_DATA, ST_TAIL, ST_DONE
  } tx_state_e;

  typedef struct packed {
    logic [15:0] len;
    logic [2:0]  flags;
    logic [7:0]  proto;
    logic [12:0] offset;
  } ip_meta_t;

  // Two end-around-carry folds are enough for a sum of nine 16-bit words.
  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction
endpackage

// File: rtl/ip_tx_if.sv
// 64-bit AXI-Stream bundle with left-aligned keep; user width per instance.
interface ip_tx_if #(parameter int USER_W = 56) ();
  logic [63:0]       data;
  logic [7:0]        keep;
  logic [USER_W-1:0] user;
  logic              last;
  logic              valid;
  logic              ready;

  modport master (output data, keep, user, last, valid, input ready);
  modport slave  (input data, keep, user, last, valid, output ready);
endinterface

// File: rtl/ip_tx_buf.sv
// First-word-fall-through FIFO pair: packet beats and per-packet metadata.
module ip_tx_buf
  import ip_tx_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_d_wr,
  input  logic [DFIFO_W-1:0] i_d_din,
  input  logic               i_d_rd,
  output logic [DFIFO_W-1:0] o_d_dout,
  output logic               o_d_empty,
  output logic               o_d_full,
  output logic [9:0]         o_d_free,
  input  logic               i_u_wr,
  input  logic [UFIFO_W-1:0] i_u_din,
  input  logic               i_u_rd,
  output logic [UFIFO_W-1:0] o_u_dout,
  output logic               o_u_empty,
  output logic               o_u_full
);
  logic [DFIFO_W-1:0] r_dmem [DFIFO_D];
  logic [8:0]         r_dwp, r_drp;
  logic [9:0]         r_dcnt;
  logic               w_dwe, w_dre;

  logic [UFIFO_W-1:0] r_umem [UFIFO_D];
  logic [3:0]         r_uwp, r_urp;
  logic [4:0]         r_ucnt;
  logic               w_uwe, w_ure;

  assign o_d_full  = (r_dcnt == 10'(DFIFO_D));
  assign o_d_empty = (r_dcnt == 10'd0);
  assign o_d_free  = 10'(DFIFO_D) - r_dcnt;
  assign o_d_dout  = r_dmem[r_drp];
  assign w_dwe     = i_d_wr && !o_d_full;
  assign w_dre     = i_d_rd && !o_d_empty;

  assign o_u_full  = (r_ucnt == 5'(UFIFO_D));
  assign o_u_empty = (r_ucnt == 5'd0);
  assign o_u_dout  = r_umem[r_urp];
  assign w_uwe     = i_u_wr && !o_u_full;
  assign w_ure     = i_u_rd && !o_u_empty;

  always_ff @(posedge i_clk) begin
    if (w_dwe) r_dmem[r_dwp] <= i_d_din;
    if (w_uwe) r_umem[r_uwp] <= i_u_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dwp  <= '0;
      r_drp  <= '0;
      r_dcnt <= '0;
      r_uwp  <= '0;
      r_urp  <= '0;
      r_ucnt <= '0;
    end else begin
      if (w_dwe) r_dwp <= r_dwp + 9'd1;
      if (w_dre) r_drp <= r_drp + 9'd1;
      r_dcnt <= r_dcnt + 10'(w_dwe) - 10'(w_dre);
      if (w_uwe) r_uwp <= r_uwp + 4'd1;
      if (w_ure) r_urp <= r_urp + 4'd1;
      r_ucnt <= r_ucnt + 5'(w_uwe) - 5'(w_ure);
    end
  end
endmodule

// File: rtl/ip_tx.sv
// Buffers whole UDP segments/IP fragments, prepends an IPv4 header with
// checksum and shifts the payload by 4 bytes toward the MAC.
module ip_tx
  import ip_tx_pkg::*;
#(
  parameter logic [31:0] P_SRC_IP = 32'hC0A8_6463,
  parameter logic [31:0] P_DST_IP = 32'hC0A8_6464,
  parameter logic [7:0]  P_TTL    = 8'd64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dymanic_src_ip,
  input  logic        i_dymanic_src_valid,
  input  logic [31:0] i_dymanic_dst_ip,
  input  logic        i_dymanic_dst_valid,
  ip_tx_if.slave      s_axis_ip,
  ip_tx_if.master     m_axis_mac
);
  logic               r_ready, r_first;
  logic [4:0]         r_pkts;
  logic [31:0]        r_src_ip, r_dst_ip;
  logic               w_acc, w_room, w_u_rd, w_d_rd, w_adv, w_unused;
  logic [DFIFO_W-1:0] w_d_dout;
  logic               w_d_empty, w_d_full, w_u_empty, w_u_full;
  logic [9:0]         w_d_free;
  logic [UFIFO_W-1:0] w_u_dout;

  tx_state_e   r_state;
  ip_meta_t    r_meta;
  logic [31:0] r_hsrc, r_hdst, r_carry;
  logic [3:0]  r_ckeep;
  logic [19:0] r_sum;
  logic [15:0] r_csum, r_id, r_user, w_tot;
  logic        r_cph, r_valid, r_last;
  logic [63:0] r_data;
  logic [7:0]  r_keep;
  logic [19:0] w_sum;
  logic        w_cur_last;
  logic [7:0]  w_cur_keep;
  logic [63:0] w_cur_data;

  assign w_acc  = s_axis_ip.valid && r_ready;
  assign w_room = (w_d_free >= 10'(FREE_THRESH)) && !w_u_full;
  // Metadata is queued at packet start, but egress only begins once the
  // whole packet is buffered so the output never starves mid-packet.
  assign w_u_rd = (r_state == ST_IDLE) && (r_pkts != 5'd0) && !w_u_empty;
  assign w_adv  = !r_valid || m_axis_mac.ready;
  assign w_d_rd = (r_state == ST_DATA) && w_adv && !w_d_empty;
  assign {w_cur_last, w_cur_keep, w_cur_data} = w_d_dout;
  assign w_unused = ^{s_axis_ip.user[15:0], w_d_full};

  ip_tx_buf u_buf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_d_wr   (w_acc),
    .i_d_din  ({s_axis_ip.last, s_axis_ip.keep, s_axis_ip.data}),
    .i_d_rd   (w_d_rd),
    .o_d_dout (w_d_dout),
    .o_d_empty(w_d_empty),
    .o_d_full (w_d_full),
    .o_d_free (w_d_free),
    .i_u_wr   (w_acc && r_first),
    .i_u_din  (s_axis_ip.user[55:16]),
    .i_u_rd   (w_u_rd),
    .o_u_dout (w_u_dout),
    .o_u_empty(w_u_empty),
    .o_u_full (w_u_full)
  );

  // Ready is only re-evaluated between packets; upstream ignores backpressure.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready <= 1'b0;
      r_first <= 1'b1;
      r_pkts  <= '0;
    end else begin
      if (!r_ready) r_ready <= w_room;
      else if (w_acc && s_axis_ip.last) r_ready <= 1'b0;
      if (w_acc) r_first <= s_axis_ip.last;
      r_pkts <= r_pkts + 5'(w_acc && s_axis_ip.last) - 5'(w_u_rd);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src_ip <= P_SRC_IP;
      r_dst_ip <= P_DST_IP;
    end else begin
      if (i_dymanic_src_valid) r_src_ip <= i_dymanic_src_ip;
      if (i_dymanic_dst_valid) r_dst_ip <= i_dymanic_dst_ip;
    end
  end

  assign w_tot = r_meta.len + 16'(IP_HDR_BYTES);
  assign w_sum = 20'({IP_VER_IHL, IP_TOS}) + 20'(w_tot) + 20'(r_id)
               + 20'({r_meta.flags, r_meta.offset}) + 20'({P_TTL, r_meta.proto})
               + 20'(r_hsrc[31:16]) + 20'(r_hsrc[15:0])
               + 20'(r_hdst[31:16]) + 20'(r_hdst[15:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_meta  <= '0;
      r_hsrc  <= '0;
      r_hdst  <= '0;
      r_sum   <= '0;
      r_csum  <= '0;
      r_cph   <= 1'b0;
      r_carry <= '0;
      r_ckeep <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_user  <= '0;
    end else begin
      if (m_axis_mac.ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: if (w_u_rd) begin
          r_meta  <= ip_meta_t'(w_u_dout);
          r_hsrc  <= r_src_ip;
          r_hdst  <= r_dst_ip;
          r_cph   <= 1'b0;
          r_state <= ST_CSUM;
        end
        ST_CSUM: begin
          r_cph <= 1'b1;
          if (!r_cph) r_sum <= w_sum;
          else begin
            r_csum  <= ~csum_fold(r_sum);
            r_state <= ST_HDR0;
          end
        end
        ST_HDR0: if (w_adv) begin
          r_valid <= 1'b1;
          r_last  <= 1'b0;
          r_data  <= {IP_VER_IHL, IP_TOS, w_tot, r_id, r_meta.flags, r_meta.offset};
          r_keep  <= 8'hFF;
          r_user  <= w_tot;
          r_state <= ST_HDR1;
        end
        ST_HDR1: if (w_adv) begin
          r_valid <= 1'b1;
          r_data  <= {P_TTL, r_meta.proto, r_csum, r_hsrc};
          r_keep  <= 8'hFF;
          r_carry <= r_hdst;
          r_ckeep <= 4'hF;
          r_state <= ST_DATA;
        end
        ST_DATA: if (w_d_rd) begin
          r_valid <= 1'b1;
          r_data  <= {r_carry, w_cur_data[63:32]};
          r_keep  <= {r_ckeep, w_cur_keep[7:4]};
          r_last  <= w_cur_last && (w_cur_keep[3:0] == 4'h0);
          r_carry <= w_cur_data[31:0];
          r_ckeep <= w_cur_keep[3:0];
          if (w_cur_last) r_state <= (w_cur_keep[3:0] == 4'h0) ? ST_DONE : ST_TAIL;
        end
        ST_TAIL: if (w_adv) begin
          r_valid <= 1'b1;
          r_last  <= 1'b1;
          r_data  <= {r_carry, 32'h0};
          r_keep  <= {r_ckeep, 4'h0};
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!r_meta.flags[FLAG_MF]) r_id <= r_id + 16'd1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_ip.ready  = r_ready;
  assign m_axis_mac.valid = r_valid;
  assign m_axis_mac.last  = r_last;
  assign m_axis_mac.data  = r_data;
  assign m_axis_mac.keep  = r_keep;
  assign m_axis_mac.user  = r_user;
endmodule
